// File: rtl/rx_fifo_sched_if.sv
// rx_fifo_sched_if: FIFO-side and parser-side signals of the RX read scheduler
interface rx_fifo_sched_if #(
    parameter int AW = 8
);
    logic iwr;
    logic iemp;
    logic iflush;
    logic iswch;
    logic ordreq;
    logic osclr;
    logic oval;
    logic omrk_rstn;
    logic oovf;
    logic [AW:0] olvl;
    logic [1:0] ostate;
    modport master (
        output iwr, iemp, iflush, iswch,
        input ordreq, osclr, oval, omrk_rstn, oovf, olvl, ostate
    );
    modport slave (
        input iwr, iemp, iflush, iswch,
        output ordreq, osclr, oval, omrk_rstn, oovf, olvl, ostate
    );
endinterface

// File: rtl/rx_fifo_sched.sv
// rx_fifo_sched: RX FIFO read scheduler, fill tracker and flush sequencer
// Defining RXSCHED_BURST_EN adds burst draining when the FIFO runs three-quarters full.
module rx_fifo_sched #(
    parameter int AW = 8,
    parameter int START_LVL = 32,
    parameter int PACE = 4,
    parameter int TMO = 4095
) (
    input logic clk,
    input logic reset,
    rx_fifo_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    localparam int PW = $clog2(PACE + 1);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [AW:0] FULL = (AW+1)'(2**AW);
    localparam logic [AW:0] START = (AW+1)'(START_LVL);
    localparam logic [PW-1:0] RELOAD = PW'(PACE - 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);
    state_t state;
    logic [PW-1:0] pace, pace_nxt;
    logic [TW-1:0] tmo;
    logic [AW:0] lvl_nxt;
    logic flush_cnt, flush, wr, full_wr, drain, leave, pace_ok, burst_clr, rd_nxt;
`ifdef RXSCHED_BURST_EN
    localparam logic [AW:0] HI = (AW+1)'(2**AW - 2**AW/4);
    localparam logic [AW:0] HALF = (AW+1)'(2**AW/2);
    logic burst;
    assign burst_clr = burst && bus.olvl < HALF;
    assign pace_ok = burst ? !burst_clr : pace == '0;
`else
    assign burst_clr = 1'b0;
    assign pace_ok = pace == '0;
`endif
    assign flush = bus.iflush | bus.iswch;
    assign wr = bus.iwr && state != FLUSH;
    assign full_wr = wr && !bus.ordreq && bus.olvl == FULL;
    assign lvl_nxt = (wr && !bus.ordreq && !full_wr) ? bus.olvl + 1'b1 :
                     (!wr && bus.ordreq && bus.olvl != '0) ? bus.olvl - 1'b1 : bus.olvl;
    assign drain = tmo == TMO_V;
    assign leave = drain && bus.olvl == '0 && !bus.iwr;
    assign rd_nxt = pace_ok && bus.olvl > (AW+1)'(bus.ordreq) && !bus.iemp;
    assign pace_nxt = (rd_nxt || burst_clr) ? RELOAD : pace == '0 ? pace : pace - 1'b1;
    assign bus.ostate = state;
    // Sequencer: flush wins over every transition, level and outputs are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            flush_cnt <= 1'b0;
            pace <= '0;
            tmo <= '0;
            bus.ordreq <= 1'b0;
            bus.osclr <= 1'b0;
            bus.oval <= 1'b0;
            bus.omrk_rstn <= 1'b0;
            bus.oovf <= 1'b0;
            bus.olvl <= '0;
        end else if (flush) begin
            state <= FLUSH;
            flush_cnt <= 1'b0;
            pace <= '0;
            tmo <= '0;
            bus.ordreq <= 1'b0;
            bus.osclr <= 1'b1;
            bus.oval <= 1'b0;
            bus.omrk_rstn <= 1'b0;
            bus.oovf <= 1'b0;
            bus.olvl <= '0;
        end else begin
            bus.oval <= bus.ordreq;
            bus.olvl <= lvl_nxt;
            bus.oovf <= bus.oovf | full_wr;
            bus.ordreq <= 1'b0;
            case (state)
                IDLE: if (bus.iwr) begin
                    state <= FILL;
                    bus.omrk_rstn <= 1'b1;
                end
                FILL: if (bus.olvl >= START) begin
                    state <= RUN;
                    pace <= RELOAD;
                    tmo <= '0;
                end
                RUN: if (leave) begin
                    state <= IDLE;
                    bus.omrk_rstn <= 1'b0;
                end else begin
                    bus.ordreq <= rd_nxt;
                    pace <= pace_nxt;
                    tmo <= bus.iwr ? '0 : drain ? tmo : tmo + 1'b1;
                end
                default: if (flush_cnt) begin
                    state <= IDLE;
                    bus.osclr <= 1'b0;
                end else flush_cnt <= 1'b1;
            endcase
        end
    end
`ifdef RXSCHED_BURST_EN
    // Burst mode: set at three-quarters full, dropped below half full
    always_ff @(posedge clk) begin
        if (reset || flush) burst <= 1'b0;
        else if (state == RUN && !leave) burst <= burst ? !burst_clr : bus.olvl >= HI;
    end
`endif
endmodule
